// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte strobes to and from user logic.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low on reads until txvalid signals datasend is ready.
module i2c_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned FILTER   = 3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  output logic [7:0] datareceive,
  output logic       received,
  input  logic       rxfull,
  input  logic [7:0] datasend,
  output logic       sended,
  input  logic       txvalid,
  output logic       rw,
  output logic       busy,
  output logic [5:0] state
);

  typedef enum logic [5:0] {
    StIdle     = 6'd0,
    StAddr     = 6'd11,
    StAddrAck  = 6'd12,
    StRx       = 6'd21,
    StRxAck    = 6'd22,
    StTx       = 6'd31,
    StTxAck    = 6'd32,
    StWaitStop = 6'd63
  } state_e;

  // Bit 1 = SDA, bit 0 = SCL throughout the conditioning pipeline.
  logic [1:0] sync1_q, sync2_q, filt_q, filt_d1_q;
  logic [2:0] cnt_q [2];
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;
  logic       sda_f;

  assign sda_f = filt_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      filt_d1_q  <= 2'b11;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      sync1_q <= {sda, scl};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (cnt_q[i] == 3'(FILTER - 1)) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 3'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
      filt_d1_q  <= filt_q;
      scl_rise_q <= filt_q[0] & ~filt_d1_q[0];
      scl_fall_q <= ~filt_q[0] & filt_d1_q[0];
      start_q    <= ~filt_q[1] & filt_d1_q[1] & filt_q[0];
      stop_q     <= filt_q[1] & ~filt_d1_q[1] & filt_q[0];
    end
  end

  logic tx_ready;
`ifdef I2C_SLAVE_STRETCH_EN
  assign tx_ready = txvalid;
`else
  logic unused_txvalid;
  assign unused_txvalid = txvalid;
  assign tx_ready       = 1'b1;
`endif

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [7:0] txbyte_q, txbyte_d;
  logic [7:0] datareceive_q, datareceive_d;
  logic       rw_q, rw_d, busy_q, busy_d;
  logic       sda_low_q, sda_low_d, scl_low_q, scl_low_d;
  logic       stall_q, stall_d, ack_q, ack_d, phase_q, phase_d;
  logic       received_q, received_d, sended_q, sended_d;
  logic       load_tx;

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    txbyte_d      = txbyte_q;
    datareceive_d = datareceive_q;
    rw_d          = rw_q;
    busy_d        = busy_q;
    sda_low_d     = sda_low_q;
    scl_low_d     = scl_low_q;
    stall_d       = stall_q;
    ack_d         = ack_q;
    phase_d       = phase_q;
    received_d    = 1'b0;
    sended_d      = 1'b0;
    load_tx       = 1'b0;
    if (stop_q) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
      scl_low_d = 1'b0;
      stall_d   = 1'b0;
      phase_d   = 1'b0;
    end else if (start_q) begin
      state_d   = StAddr;
      bitcnt_d  = 3'd7;
      busy_d    = 1'b1;
      sda_low_d = 1'b0;
      scl_low_d = 1'b0;
      stall_d   = 1'b0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise_q) begin
          shreg_d  = {shreg_q[5:0], sda_f};
          bitcnt_d = bitcnt_q - 3'd1;
          if (bitcnt_q == 3'd0) begin
            if (shreg_q == DEV_ADDR) begin
              rw_d    = sda_f;
              state_d = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: if (scl_fall_q) begin
          if (!phase_q) begin
            sda_low_d = 1'b1;
            phase_d   = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
            if (rw_q) begin
              state_d = StTx;
              load_tx = 1'b1;
            end else begin
              state_d = StRx;
            end
          end
        end
        StRx: if (scl_rise_q) begin
          shreg_d  = {shreg_q[5:0], sda_f};
          bitcnt_d = bitcnt_q - 3'd1;
          if (bitcnt_q == 3'd0) begin
            ack_d   = ~rxfull;
            state_d = StRxAck;
            if (!rxfull) begin
              datareceive_d = {shreg_q, sda_f};
              received_d    = 1'b1;
            end
          end
        end
        StRxAck: if (scl_fall_q) begin
          if (!phase_q) begin
            sda_low_d = ack_q;
            phase_d   = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
            state_d   = StRx;
          end
        end
        StTx: begin
          if (stall_q) begin
            if (tx_ready) begin
              txbyte_d  = datasend;
              sended_d  = 1'b1;
              sda_low_d = ~datasend[7];
              scl_low_d = 1'b0;
              stall_d   = 1'b0;
            end
          end else if (scl_rise_q) begin
            bitcnt_d = bitcnt_q - 3'd1;
          end else if (scl_fall_q) begin
            // Counter back at 7 means all eight bits have been clocked out.
            if (bitcnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = StTxAck;
            end else begin
              sda_low_d = ~txbyte_q[bitcnt_q];
            end
          end
        end
        StTxAck: begin
          if (!phase_q) begin
            if (scl_rise_q) begin
              if (sda_f) state_d = StWaitStop;
              else       phase_d = 1'b1;
            end
          end else if (scl_fall_q) begin
            phase_d = 1'b0;
            state_d = StTx;
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_tx) begin
        if (tx_ready) begin
          txbyte_d  = datasend;
          sended_d  = 1'b1;
          sda_low_d = ~datasend[7];
        end else begin
          stall_d   = 1'b1;
          scl_low_d = 1'b1;
          sda_low_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bitcnt_q      <= 3'd7;
      shreg_q       <= '0;
      txbyte_q      <= '0;
      datareceive_q <= '0;
      rw_q          <= 1'b0;
      busy_q        <= 1'b0;
      sda_low_q     <= 1'b0;
      scl_low_q     <= 1'b0;
      stall_q       <= 1'b0;
      ack_q         <= 1'b0;
      phase_q       <= 1'b0;
      received_q    <= 1'b0;
      sended_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      txbyte_q      <= txbyte_d;
      datareceive_q <= datareceive_d;
      rw_q          <= rw_d;
      busy_q        <= busy_d;
      sda_low_q     <= sda_low_d;
      scl_low_q     <= scl_low_d;
      stall_q       <= stall_d;
      ack_q         <= ack_d;
      phase_q       <= phase_d;
      received_q    <= received_d;
      sended_q      <= sended_d;
    end
  end

  assign sda         = sda_low_q ? 1'b0 : 1'bz;
  assign scl         = scl_low_q ? 1'b0 : 1'bz;
  assign datareceive = datareceive_q;
  assign received    = received_q;
  assign sended      = sended_q;
  assign rw          = rw_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, scoreboard queues for written and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam int H = 40;
  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       reset;
  wire        sda, scl;
  logic       m_sda_low = 1'b0, m_scl_low = 1'b0;
  logic [7:0] datareceive, datasend;
  logic       received, sended, rxfull, txvalid, rw, busy;
  logic [5:0] state;

  pullup (sda);
  pullup (scl);
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl),
    .datareceive(datareceive), .received(received), .rxfull(rxfull),
    .datasend(datasend), .sended(sended), .txvalid(txvalid),
    .rw(rw), .busy(busy), .state(state)
  );

  int checks = 0, errors = 0, rx_cnt = 0, tx_cnt = 0;
  logic [7:0] exp_rx[$], exp_rd[$], act_rd[$], src[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scores received bytes and bus-read bytes; feeds the next datasend on each sended.
  initial forever begin
    @(negedge clk);
    if (received === 1'b1) begin
      rx_cnt++;
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got %0h with nothing expected", datareceive);
      end else chk("rx_byte", datareceive, exp_rx.pop_front());
    end
    if (sended === 1'b1) begin
      tx_cnt++;
      if (src.size() != 0) datasend = src.pop_front();
    end
    if (act_rd.size() != 0) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %0h with nothing expected", act_rd.pop_front());
      end else chk("rd_byte", act_rd.pop_front(), exp_rd.pop_front());
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic scl_release();
    int n = 0;
    m_scl_low = 1'b0;
    while (scl !== 1'b1 && n < 4000) begin @(posedge clk); n++; end
    chk("scl_release", scl, 1);
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0; repeat (Q) @(posedge clk);
    scl_release();    repeat (H) @(posedge clk);
    m_sda_low = 1'b1; repeat (H) @(posedge clk);
    m_scl_low = 1'b1; repeat (Q) @(posedge clk);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; repeat (Q) @(posedge clk);
    scl_release();    repeat (H) @(posedge clk);
    m_sda_low = 1'b0;
  endtask

  task automatic stop_and_idle(input string tag);
    int n = 0;
    stop_cond();
    while (busy !== 1'b0 && n < 30) begin @(posedge clk); n++; end
    chk({tag, "_busy_fall_in_time"}, 32'(n <= 10), 1);
    chk({tag, "_state_idle"}, state, 0);
    repeat (H) @(posedge clk);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b;   repeat (Q) @(posedge clk);
    scl_release();    repeat (H) @(posedge clk);
    m_scl_low = 1'b1; repeat (Q) @(posedge clk);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; repeat (Q) @(posedge clk);
    scl_release();    repeat (H / 2) @(posedge clk);
    b = sda;          repeat (H / 2) @(posedge clk);
    m_scl_low = 1'b1; repeat (Q) @(posedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    act_rd.push_back(d);
    write_bit(~ack);
  endtask

  initial begin
    logic ack, b;
    int rx0, tx0, n;
    reset = 1'b1; rxfull = 1'b0; txvalid = 1'b1; datasend = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_datareceive", datareceive, 0);
    chk("rst_received", received, 0);
    chk("rst_sended", sended, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Write 0x12, 0x34 to the device.
    rx0 = rx_cnt;
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
    start_cond();
    chk("t1_busy", busy, 1);
    write_byte(8'hA0, ack); chk("t1_addr_ack", ack, 1); chk("t1_rw", rw, 0);
    write_byte(8'h12, ack); chk("t1_d0_ack", ack, 1);
    write_byte(8'h34, ack); chk("t1_d1_ack", ack, 1);
    stop_and_idle("t1");
    chk("t1_rx_cnt", rx_cnt - rx0, 2);
    chk("t1_rx_drain", exp_rx.size(), 0);

    // Foreign address: never acknowledged.
    rx0 = rx_cnt; tx0 = tx_cnt;
    start_cond();
    write_byte(8'hA2, ack); chk("t2_addr_nack", ack, 0); chk("t2_state", state, 63);
    write_byte(8'h55, ack); chk("t2_data_nack", ack, 0); chk("t2_state2", state, 63);
    stop_and_idle("t2");
    chk("t2_no_rx", rx_cnt - rx0, 0);
    chk("t2_no_tx", tx_cnt - tx0, 0);

    // Read two bytes, ACK the first, NACK the second.
    tx0 = tx_cnt;
    datasend = 8'hA5; src.push_back(8'h3C);
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h3C);
    start_cond();
    write_byte(8'hA1, ack); chk("t3_addr_ack", ack, 1); chk("t3_rw", rw, 1);
    read_byte(1'b1);
    read_byte(1'b0);
    chk("t3_state_nack", state, 63);
    stop_and_idle("t3");
    chk("t3_tx_cnt", tx_cnt - tx0, 2);
    chk("t3_rd_drain", exp_rd.size(), 0);

    // rxfull during the data byte: NACK, no strobe.
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hA0, ack); chk("t4_addr_ack", ack, 1);
    rxfull = 1'b1;
    write_byte(8'h01, ack); chk("t4_data_nack", ack, 0);
    rxfull = 1'b0;
    stop_and_idle("t4");
    chk("t4_no_rx", rx_cnt - rx0, 0);

    // Write, repeated START, read.
    rx0 = rx_cnt; tx0 = tx_cnt;
    exp_rx.push_back(8'h07);
    start_cond();
    write_byte(8'hA0, ack); chk("t5_addr_ack", ack, 1); chk("t5_rw_w", rw, 0);
    write_byte(8'h07, ack); chk("t5_data_ack", ack, 1);
    datasend = 8'h99; exp_rd.push_back(8'h99);
    start_cond();
    write_byte(8'hA1, ack); chk("t5_raddr_ack", ack, 1); chk("t5_rw_r", rw, 1);
    chk("t5_busy", busy, 1);
    read_byte(1'b0);
    chk("t5_state_nack", state, 63);
    stop_and_idle("t5");
    chk("t5_rx_cnt", rx_cnt - rx0, 1);
    chk("t5_tx_cnt", tx_cnt - tx0, 1);
    chk("t5_drain", exp_rx.size() + exp_rd.size(), 0);

    // Asynchronous reset while the slave drives bit 4 of a read byte.
    datasend = 8'h00;
    start_cond();
    write_byte(8'hA1, ack); chk("t6_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) read_bit(b);
    chk("t6_sda_driven", sda, 0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("t6_sda_released", sda, 1);
    chk("t6_state", state, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    stop_cond();
    repeat (H) @(posedge clk);
    rx0 = rx_cnt;
    exp_rx.push_back(8'h5C);
    start_cond();
    write_byte(8'hA0, ack); chk("t6b_addr_ack", ack, 1);
    write_byte(8'h5C, ack); chk("t6b_data_ack", ack, 1);
    stop_and_idle("t6b");
    chk("t6b_rx_cnt", rx_cnt - rx0, 1);

`ifdef I2C_SLAVE_STRETCH_EN
    // Stretch: SCL held low while txvalid is low.
    txvalid = 1'b0; datasend = 8'h00; exp_rd.push_back(8'h5A);
    start_cond();
    write_byte(8'hA1, ack); chk("t7_addr_ack", ack, 1);
    fork
      read_byte(1'b0);
      begin
        n = 0;
        while (state !== 6'd31 && n < 4000) begin @(posedge clk); n++; end
        chk("t7_state_tx", state, 31);
        repeat (500) @(posedge clk);
        chk("t7_scl_held", scl, 0);
        datasend = 8'h5A; txvalid = 1'b1;
      end
    join
    stop_and_idle("t7");
    chk("t7_rd_drain", exp_rd.size(), 0);
`endif

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
